serial_word_tx: RTL and testbench
=================================

Name: serial_word_tx

Overview:
Upstream feeder for the parallel/serial shift register.
- Accepts a NBITS_DATA-bit word over a valid/ready handshake.
- Serializes the word LSB-first inside a start/stop frame on ser_bit.
- Drives ser_shift as a one-cycle strobe per data bit, so a right-shifting register loading its MSB from ser_bit holds the word aligned after NBITS_DATA strobes.

Parameters:
NBITS_DATA, 4, data word width (≥2)
CLKS_PER_BIT, 4, clk cycles per serial bit period (≥1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
tx_data  input  NBITS_DATA  word to send; sampled on accept
tx_valid  input  1  tx_data valid
tx_ready  output  1  block can accept a word (high only in IDLE)
ser_bit  output  1  serial line; idle level 1
ser_shift  output  1  one-cycle strobe in the last cycle of each data-bit period; drives downstream SEL
ser_busy  output  1  frame in progress (state ≠ IDLE)
word_done  output  1  one-cycle pulse in the last cycle of STOP

Behaviour:
- Reset is asynchronous, active-high; clk is the only clock.
- Reset values: state=IDLE, tx_ready=1, ser_bit=1, ser_shift=0, ser_busy=0, word_done=0, all counters=0, shift holding register=0.
- All outputs are registered or decoded from registered state only. No combinational path from tx_valid/tx_data to outputs except tx_ready, which is a state decode.
- Accept: tx_valid & tx_ready at edge k.
  - Latch tx_data into the holding register.
  - State=START from cycle k+1.
  - tx_data is don't-care after the accept edge.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- Bit timer clk_cnt counts 0..CLKS_PER_BIT-1 in every non-IDLE state. Wrap to 0 ends the bit period and advances bit_cnt or the state.
- START: ser_bit=0 for CLKS_PER_BIT cycles.
- DATA: bit i (i=0..NBITS_DATA-1) is driven for CLKS_PER_BIT cycles each.
  - ser_bit = holding[0]; the holding register shifts right at each period end.
  - ser_shift=1 exactly when clk_cnt==CLKS_PER_BIT-1.
  - Leave DATA after bit_cnt==NBITS_DATA-1 completes.
- STOP: ser_bit=1 for CLKS_PER_BIT cycles. word_done=1 in the last cycle; the next state is IDLE.
- ser_shift is 0 in every state except DATA. Exactly NBITS_DATA strobes per frame.
- Frame length: (NBITS_DATA+2)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT with parity enabled.
- Back-to-back: at least one IDLE cycle (tx_ready=1) between frames. With tx_valid held high, the next accept occurs on the first IDLE cycle.
- tx_valid during busy: ignored, no stall side effects. The upstream must hold tx_valid until ready.
- CLKS_PER_BIT=1: each period is one cycle; ser_shift is high on every DATA cycle.
- Reset mid-frame:
  - Immediate return to IDLE with all reset values; the line goes high.
  - No word_done; the partial word is discarded.
  - Downstream content is undefined and is the consumer's concern.
- Counter widths: clk_cnt is $clog2(CLKS_PER_BIT) bits, minimum 1. bit_cnt is $clog2(NBITS_DATA) bits. No overflow past terminal values.

Optional Feature:
Macro: SERIAL_TX_PARITY_EN
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - ser_bit = even parity, i.e. XOR of the accepted word computed at accept, for CLKS_PER_BIT cycles.
  - ser_shift=0 throughout PARITY.
- Undefined: PARITY state, the parity register and its logic are absent; DATA goes directly to STOP.

Decomposition:
- Package serial_pkg:
  - NBITS_DATA default constant.
  - State enum tx_state_t {IDLE, START, DATA, PARITY, STOP}. PARITY is present always in the enum and unused when the macro is undefined.
  - Helper function even_parity(word).
- Sub-module bit_timer (parameter CLKS_PER_BIT):
  - Inputs: clk, reset, run.
  - Output: period_end pulse.
  - Counter clears while run=0.

Test Plan:
1. NBITS=4, CLKS=4, accept 4'b1011 -> ser_bit sequence 0,1,1,0,1,1, each held 4 cycles; ser_shift pulses at cycles 8,12,16,20 after accept; word_done at cycle 24; downstream register = 4'b1011.
2. CLKS=1, tx_valid held high with words 4'hA then 4'h5 -> frames of 6 cycles each separated by exactly 1 IDLE cycle; 4 strobes per frame; downstream holds 4'hA, then 4'h5.
3. Assert reset during DATA bit 2 of 4'hF -> next cycle ser_bit=1, tx_ready=1, ser_shift=0, no word_done; next accept of 4'h3 sends a correct frame.
4. tx_valid toggled with tx_data changed while busy -> frame carries only the word latched at accept; no extra strobes.
5. SERIAL_TX_PARITY_EN defined, word 4'b0111 -> parity bit 1 for 4 cycles before STOP, ser_shift=0 in that period, frame length 28 cycles; with 4'b0101 parity bit=0.
6. Idle for 50 cycles after reset -> ser_bit=1, ser_shift=0, word_done=0 constantly.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial word transmitter.
// The PARITY state exists in the enum regardless of SERIAL_TX_PARITY_EN.
package serial_pkg;

    localparam int NBITS_DATA_DFLT   = 4;
    localparam int CLKS_PER_BIT_DFLT = 4;
    localparam int PAR_MAX_W         = 64;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Callers zero-extend the word; zero padding leaves the XOR unchanged.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/serial_word_tx_if.sv
// Handshake and serial-line bundle between the upstream feeder and the transmitter.
interface serial_word_tx_if
    import serial_pkg::*;
#(
    parameter int NBITS_DATA = NBITS_DATA_DFLT
);
    logic [NBITS_DATA-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  ser_bit;
    logic                  ser_shift;
    logic                  ser_busy;
    logic                  word_done;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, ser_bit, ser_shift, ser_busy, word_done
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, ser_bit, ser_shift, ser_busy, word_done
    );
endinterface

// File: rtl/serial_word_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high, pulses period_end
// on the terminal count and clears whenever run is low.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic period_end
);
    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] clk_cnt_q, clk_cnt_d;

    assign period_end = run && (clk_cnt_q == LAST);

    always_comb begin
        clk_cnt_d = clk_cnt_q + 1'b1;
        if (!run || period_end)
            clk_cnt_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            clk_cnt_q <= '0;
        else
            clk_cnt_q <= clk_cnt_d;
    end

endmodule

// File: rtl/serial_word_tx.sv
// Serializes one word LSB-first in a start/stop frame, strobing ser_shift per data bit.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module serial_word_tx
    import serial_pkg::*;
#(
    parameter int NBITS_DATA   = NBITS_DATA_DFLT,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DFLT
) (
    input  logic            clk,
    input  logic            reset,
    serial_word_tx_if.slave bus
);
    localparam int            BW       = $clog2(NBITS_DATA);
    localparam logic [BW-1:0] LAST_BIT = BW'(NBITS_DATA - 1);

    tx_state_t             state_q, state_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [NBITS_DATA-1:0] hold_q, hold_d;
    logic                  run;
    logic                  period_end;
`ifdef SERIAL_TX_PARITY_EN
    logic                  par_q, par_d;
`endif

    assign run = (state_q != IDLE);

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .period_end (period_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            hold_q    <= '0;
`ifdef SERIAL_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            hold_q    <= hold_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        hold_d    = hold_q;
`ifdef SERIAL_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.tx_valid) begin
                    state_d = START;
                    hold_d  = bus.tx_data;
`ifdef SERIAL_TX_PARITY_EN
                    par_d   = even_parity(PAR_MAX_W'(bus.tx_data));
`endif
                end
            end
            START: begin
                if (period_end)
                    state_d = DATA;
            end
            DATA: begin
                // The LSB is always on the line; shifting exposes the next bit.
                if (period_end) begin
                    hold_d = hold_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (period_end)
                    state_d = STOP;
            end
`endif
            STOP: begin
                if (period_end)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode only registered state and the registered bit timer.
    always_comb begin
        bus.tx_ready  = (state_q == IDLE);
        bus.ser_busy  = (state_q != IDLE);
        bus.ser_shift = 1'b0;
        bus.word_done = 1'b0;
        bus.ser_bit   = 1'b1;
        case (state_q)
            START: bus.ser_bit = 1'b0;
            DATA: begin
                bus.ser_bit   = hold_q[0];
                bus.ser_shift = period_end;
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: bus.ser_bit = par_q;
`endif
            STOP: bus.word_done = period_end;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_serial_word_tx.sv
// Self-checking bench: two transmitters (4 and 1 clocks per bit) compared every cycle
// against a frame-position model, plus literal pins on directed frames.
module tb_serial_word_tx;
    localparam int N  = 4;
    localparam int C4 = 4;
    localparam int C1 = 1;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int L4 = (N + 2 + PB) * C4;
    localparam int L1 = (N + 2 + PB) * C1;
    localparam logic [4:0] IDLE_OUT = 5'b11000;  // ready, bit, shift, busy, done

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serial_word_tx_if #(.NBITS_DATA(N)) if4 ();
    serial_word_tx_if #(.NBITS_DATA(N)) if1 ();

    serial_word_tx #(.NBITS_DATA(N), .CLKS_PER_BIT(C4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4)
    );
    serial_word_tx #(.NBITS_DATA(N), .CLKS_PER_BIT(C1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    int errors = 0;
    int checks = 0;

    // Model: position within the current frame, -1 when idle.
    int           pos4 = -1, pos1 = -1;
    logic [N-1:0] w4 = '0, w1 = '0;
    logic [N-1:0] ds4 = '0, ds1 = '0;

    logic         pin_en4 = 1'b0, pin_en1 = 1'b0;
    logic [N-1:0] pin_w4 [5] = '{4'b1011, 4'b0111, 4'b0101, 4'b0011, 4'b0110};
    logic         pin_p4 [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [N-1:0] pin_w1 [2] = '{4'hA, 4'h5};
    int           shift_at4 [4] = '{8, 12, 16, 20};
    int           idx4 = 0, idx1 = 0, sc4 = 0, sc1 = 0, pi4 = 0, pi1 = 0, gap1 = 0;
    logic         seen_done1 = 1'b0;

    function automatic logic [4:0] exp_out(input int cpb, input logic [N-1:0] w, input int j);
        int   p, ph;
        logic b, sh, dn;
        p  = j / cpb;
        ph = j % cpb;
        sh = 1'b0;
        dn = 1'b0;
        if (p == 0) begin
            b = 1'b0;
        end else if (p <= N) begin
            b  = w[p-1];
            sh = (ph == cpb - 1);
        end else if (PB == 1 && p == N + 1) begin
            b = ^w;
        end else begin
            b  = 1'b1;
            dn = (ph == cpb - 1);
        end
        return {1'b0, b, sh, 1'b1, dn};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) pos4 <= -1;
        else if (pos4 >= 0) pos4 <= (pos4 == L4 - 1) ? -1 : pos4 + 1;
        else if (if4.tx_valid) begin
            pos4 <= 0;
            w4   <= if4.tx_data;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) pos1 <= -1;
        else if (pos1 >= 0) pos1 <= (pos1 == L1 - 1) ? -1 : pos1 + 1;
        else if (if1.tx_valid) begin
            pos1 <= 0;
            w1   <= if1.tx_data;
        end
    end

    // Downstream right-shift register loading its MSB from ser_bit.
    always @(posedge clk) begin
        if (if4.ser_shift) ds4 <= {if4.ser_bit, ds4[N-1:1]};
        if (if1.ser_shift) ds1 <= {if1.ser_bit, ds1[N-1:1]};
    end

    always @(negedge clk) begin
        logic [4:0] e4, a4, e1, a1;
        e4 = (pos4 < 0) ? IDLE_OUT : exp_out(C4, w4, pos4);
        e1 = (pos1 < 0) ? IDLE_OUT : exp_out(C1, w1, pos1);
        a4 = {if4.tx_ready, if4.ser_bit, if4.ser_shift, if4.ser_busy, if4.word_done};
        a1 = {if1.tx_ready, if1.ser_bit, if1.ser_shift, if1.ser_busy, if1.word_done};
        chk("outs4", 32'(a4), 32'(e4));
        chk("outs1", 32'(a1), 32'(e1));
        if (e4[0]) chk("word4", 32'(ds4), 32'(w4));
        if (e1[0]) chk("word1", 32'(ds1), 32'(w1));

        idx4 = if4.ser_busy ? idx4 + 1 : 0;
        if (!if4.ser_busy) sc4 = 0;
        if (pin_en4 && if4.ser_shift)
            chk("shift_at4", 32'(idx4), (sc4 < 4) ? 32'(shift_at4[sc4]) : 32'hffffffff);
        if (if4.ser_shift) sc4++;
`ifdef SERIAL_TX_PARITY_EN
        if (pin_en4 && idx4 >= 21 && idx4 <= 24 && pi4 < 5)
            chk("parity4", 32'(if4.ser_bit), 32'(pin_p4[pi4]));
`endif
        if (pin_en4 && if4.word_done) begin
            chk("len4", 32'(idx4), (PB == 1) ? 32'd28 : 32'd24);
            chk("nshift4", 32'(sc4), 32'd4);
            if (pi4 < 5) chk("pinword4", 32'(ds4), 32'(pin_w4[pi4]));
            else         chk("extra_done4", 32'(pi4), 32'd4);
            pi4++;
        end

        idx1 = if1.ser_busy ? idx1 + 1 : 0;
        if (!if1.ser_busy) begin
            sc1 = 0;
            gap1++;
        end
        if (if1.ser_shift) sc1++;
        if (pin_en1 && if1.ser_busy && idx1 == 1 && seen_done1) begin
            chk("gap1", 32'(gap1), 32'd1);
            seen_done1 = 1'b0;
        end
        if (pin_en1 && if1.word_done) begin
            chk("len1", 32'(idx1), (PB == 1) ? 32'd7 : 32'd6);
            chk("nshift1", 32'(sc1), 32'd4);
            if (pi1 < 2) chk("pinword1", 32'(ds1), 32'(pin_w1[pi1]));
            else         chk("extra_done1", 32'(pi1), 32'd1);
            pi1++;
            gap1       = 0;
            seen_done1 = 1'b1;
        end
    end

    task automatic send(input bit sel, input logic [N-1:0] w, input bit hold);
        int n;
        n = 0;
        if (sel) begin if1.tx_valid = 1'b1; if1.tx_data = w; end
        else     begin if4.tx_valid = 1'b1; if4.tx_data = w; end
        while ((sel ? if1.tx_ready : if4.tx_ready) !== 1'b1) begin
            if (n++ > 200) begin
                $display("FAIL send_timeout: tx_ready stayed low, required 1");
                $fatal(1, "handshake stalled");
            end
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        if (!hold) begin
            if (sel) if1.tx_valid = 1'b0;
            else     if4.tx_valid = 1'b0;
        end
    endtask

    initial begin
        reset        = 1'b1;
        if4.tx_valid = 1'b0;
        if4.tx_data  = '0;
        if1.tx_valid = 1'b0;
        if1.tx_data  = '0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        repeat (50) @(negedge clk);

        pin_en4 = 1'b1;
        send(1'b0, 4'b1011, 1'b0);
        repeat (30) @(negedge clk);
        send(1'b0, 4'b0111, 1'b0);
        repeat (30) @(negedge clk);
        send(1'b0, 4'b0101, 1'b0);
        repeat (30) @(negedge clk);

        // Cut 4'hF off in the middle of data bit 2.
        send(1'b0, 4'hF, 1'b0);
        repeat (13) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        send(1'b0, 4'h3, 1'b0);
        repeat (30) @(negedge clk);

        // Input churn while busy must not disturb the latched word.
        send(1'b0, 4'h6, 1'b0);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if4.tx_valid = 1'($urandom_range(0, 1));
            if4.tx_data  = N'($urandom);
        end
        @(negedge clk);
        if4.tx_valid = 1'b0;
        repeat (20) @(negedge clk);
        pin_en4 = 1'b0;

        pin_en1 = 1'b1;
        send(1'b1, 4'hA, 1'b1);
        if1.tx_data = 4'h5;
        send(1'b1, 4'h5, 1'b0);
        repeat (15) @(negedge clk);
        pin_en1 = 1'b0;

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if4.tx_valid = ($urandom_range(0, 3) != 0);
            if4.tx_data  = N'($urandom);
            if1.tx_valid = ($urandom_range(0, 3) != 0);
            if1.tx_data  = N'($urandom);
            if (i == 700) #1 reset = 1'b1;
            if (i == 702) #1 reset = 1'b0;
        end
        @(negedge clk);
        if4.tx_valid = 1'b0;
        if1.tx_valid = 1'b0;
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
